smooth_scheduler: RTL

Sequences repeated smoothing passes of the neighbour-averaging engine over a mesh held in object RAM. For each pass it launches the averager, waits for it to finish, then copies the result RAM back into object RAM so the next pass reads smoothed coordinates. It owns the RAM port multiplexer selection between the host loader, the averager and its own copy engine, and reports completion or handshake failure to the host.

---
 rtl/smooth_scheduler.sv | 110 +++++++++++
 1 files changed

// File: rtl/smooth_scheduler.sv
// smooth_scheduler: runs N averager passes, copying result RAM words 1..3V into object RAM after each; host start/busy/done/error/passes_done, averager avg_start/avg_busy, RAM mux ram_sel, copy ports cp_*
module smooth_scheduler #(
  parameter int ADDR_WIDTH    = 9,
  parameter int ITER_WIDTH    = 4,
  parameter int START_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ITER_WIDTH-1:0] iterations,
  input  logic [31:0]           vertex_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ITER_WIDTH-1:0] passes_done,
  output logic                  avg_start,
  input  logic                  avg_busy,
  output logic [1:0]            ram_sel,
  output logic                  cp_res_en,
  output logic [ADDR_WIDTH-1:0] cp_res_a,
  input  logic [31:0]           res_do,
  output logic                  cp_obj_en,
  output logic [3:0]            cp_obj_we,
  output logic [ADDR_WIDTH-1:0] cp_obj_a,
  output logic [31:0]           cp_obj_di
);
  localparam int CW = $clog2(START_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO, COPY, FINISH} state_t;
  state_t                  state_q;
  logic [ITER_WIDTH-1:0]   n_q;
  logic [31:0]             v_q;
  logic [CW-1:0]           cnt_q;
  logic [ADDR_WIDTH-1:0]   last_a;
  logic [ITER_WIDTH-1:0]   next_p;
  assign last_a    = ADDR_WIDTH'(v_q * 32'd3);
  assign next_p    = passes_done + 1'b1;
  assign cp_obj_di = cp_obj_en ? res_do : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      v_q         <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      passes_done <= '0;
      avg_start   <= 1'b0;
      ram_sel     <= 2'd0;
      cp_res_en   <= 1'b0;
      cp_res_a    <= '0;
      cp_obj_en   <= 1'b0;
      cp_obj_we   <= 4'b0000;
      cp_obj_a    <= '0;
    end else begin
      done      <= 1'b0;
      cp_obj_en <= cp_res_en;
      cp_obj_we <= {4{cp_res_en}};
      cp_obj_a  <= cp_res_a;
      case (state_q)
        IDLE: if (start) begin
          n_q         <= iterations;
          v_q         <= vertex_count;
          passes_done <= '0;
          error       <= 1'b0;
          busy        <= 1'b1;
          if (iterations == '0 || vertex_count == '0) state_q <= FINISH;
          else begin
            state_q <= LAUNCH;
            ram_sel <= 2'd1;
          end
        end
        LAUNCH: begin
          avg_start <= 1'b1;
          cnt_q     <= '0;
          state_q   <= WAIT_HI;
        end
        WAIT_HI: if (avg_busy) begin
          avg_start <= 1'b0;
          state_q   <= WAIT_LO;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          error     <= 1'b1;
          avg_start <= 1'b0;
          ram_sel   <= 2'd0;
          state_q   <= FINISH;
        end else cnt_q <= cnt_q + 1'b1;
        WAIT_LO: if (!avg_busy) begin
          ram_sel   <= 2'd2;
          cp_res_en <= 1'b1;
          cp_res_a  <= ADDR_WIDTH'(1);
          state_q   <= COPY;
        end
        COPY: if (cp_res_en) begin
          cp_res_en <= cp_res_a != last_a;
          cp_res_a  <= cp_res_a == last_a ? '0 : cp_res_a + 1'b1;
        end else begin
          passes_done <= next_p;
          ram_sel     <= next_p == n_q ? 2'd0 : 2'd1;
          state_q     <= next_p == n_q ? FINISH : LAUNCH;
        end
        FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
